// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: write record and grant source.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LU   = 2'd2
  } grant_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of register writes; head is visible combinationally.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  rf_wr_t wr,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rf_wr_t      mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/rf_write_arbiter.sv
// Single regfile write port shared by in-order writeback and a long-latency unit,
// with an LU result FIFO, starvation guard and a busy scoreboard for ID hazards.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int LU_DEPTH = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_stall,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_addr,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rd_valid,
  output logic                  id_stall,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] wt_addr,
  output logic [XLEN-1:0]       wt_data
);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  rf_wr_t              head;
  rf_wr_t              push_wr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                force_lu;
  grant_t              grant;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wt_from_lu;
  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:0] busy_vec;

  rf_wr_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wr    (push_wr),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // WB normally wins; a head blocked for MAX_WAIT cycles takes the port instead.
  always_comb begin
    force_lu = !empty && (wait_cnt == WAIT_W'(MAX_WAIT));
    if (force_lu)      grant = GNT_LU;
    else if (wb_valid) grant = GNT_WB;
    else if (!empty)   grant = GNT_LU;
    else               grant = GNT_NONE;
  end

  assign pop      = (grant == GNT_LU);
  assign wb_stall = force_lu & wb_valid;
  assign lu_ready = !full | pop;
  assign push     = lu_valid & lu_ready;
  assign push_wr  = {lu_addr, lu_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (pop || empty)    wait_cnt <= '0;
    else if (grant == GNT_WB) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      wt_addr    <= '0;
      wt_data    <= '0;
      wt_from_lu <= 1'b0;
    end else begin
      unique case (grant)
        GNT_LU: begin
          reg_write  <= (head.addr != '0);
          wt_addr    <= head.addr;
          wt_data    <= head.data;
          wt_from_lu <= 1'b1;
        end
        GNT_WB: begin
          reg_write  <= (wb_addr != '0);
          wt_addr    <= wb_addr;
          wt_data    <= wb_data;
          wt_from_lu <= 1'b0;
        end
        default: begin
          reg_write  <= 1'b0;
          wt_from_lu <= 1'b0;
        end
      endcase
    end
  end

  // Busy clears on the edge the LU result lands in the regfile; a new issue wins a tie.
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          busy[gi] <= 1'b0;
        else if (lu_issue && (lu_issue_addr == REG_ADDR_W'(gi)))
          busy[gi] <= 1'b1;
        else if (reg_write && wt_from_lu && (wt_addr == REG_ADDR_W'(gi)))
          busy[gi] <= 1'b0;
      end
    end
  endgenerate

  assign busy_vec = {busy, 1'b0};
  assign id_stall = busy_vec[id_rs1_addr] | busy_vec[id_rs2_addr]
                  | (id_rd_valid & busy_vec[id_rd_addr]);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int LU_DEPTH = 2;
  localparam int MAX_WAIT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wb_valid, lu_issue, lu_valid, id_rd_valid;
  logic [4:0]      wb_addr, lu_issue_addr, lu_addr, id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] wb_data, lu_data;
  logic            wb_stall, lu_ready, id_stall, reg_write;
  logic [4:0]      wt_addr;
  logic [XLEN-1:0] wt_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.LU_DEPTH(LU_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rd_valid(id_rd_valid), .id_stall(id_stall),
    .reg_write(reg_write), .wt_addr(wt_addr), .wt_data(wt_data)
  );

  // Reference model: LU queue, blocked-head age, busy set, pending regfile write.
  rf_wr_t          m_q[$];
  int              m_wait;
  bit              m_busy[32];
  bit              m_rw;
  logic [4:0]      m_wa;
  logic [XLEN-1:0] m_wd;
  bit              m_wlu;
  int              m_gnt;
  bit              e_stall, e_ready, e_id;

  task automatic model_reset();
    m_q.delete();
    m_wait = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_rw = 0; m_wa = '0; m_wd = '0; m_wlu = 0;
  endtask

  task automatic model_comb();
    bit starved;
    starved = (m_q.size() > 0) && (m_wait == MAX_WAIT);
    if (starved)              m_gnt = 2;
    else if (wb_valid)        m_gnt = 1;
    else if (m_q.size() > 0)  m_gnt = 2;
    else                      m_gnt = 0;
    e_stall = starved && wb_valid;
    e_ready = (m_q.size() < LU_DEPTH) || (m_gnt == 2);
    e_id    = m_busy[id_rs1_addr] || m_busy[id_rs2_addr] || (id_rd_valid && m_busy[id_rd_addr]);
  endtask

  task automatic tick();
    rf_wr_t h;
    bit     accept;
    model_comb();
    accept = lu_valid && e_ready;
    if (m_rw && m_wlu) m_busy[m_wa] = 1'b0;
    if (lu_issue && lu_issue_addr != 0) m_busy[lu_issue_addr] = 1'b1;
    case (m_gnt)
      2: begin
        h = m_q.pop_front();
        m_rw = (h.addr != 0); m_wa = h.addr; m_wd = h.data; m_wlu = 1; m_wait = 0;
      end
      1: begin
        m_rw = (wb_addr != 0); m_wa = wb_addr; m_wd = wb_data; m_wlu = 0;
        if (m_q.size() > 0) m_wait++;
      end
      default: begin
        m_rw = 0; m_wlu = 0; m_wait = 0;
      end
    endcase
    if (accept) begin
      h.addr = lu_addr; h.data = lu_data;
      m_q.push_back(h);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    lu_issue = 0; lu_issue_addr = '0;
    lu_valid = 0; lu_addr = '0; lu_data = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rd_valid = 0;
  endtask

  task automatic issue(input logic [4:0] a);
    lu_issue = 1; lu_issue_addr = a;
    tick();
    lu_issue = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (reg_write !== 1'b0) begin miscompares++; $display("FAIL reset.reg_write got %b exp 0", reg_write); end
    vectors++; if (wt_addr !== 5'd0) begin miscompares++; $display("FAIL reset.wt_addr got %0d exp 0", wt_addr); end
    vectors++; if (wt_data !== '0) begin miscompares++; $display("FAIL reset.wt_data got %h exp 0", wt_data); end
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL reset.lu_ready got %b exp 1", lu_ready); end
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL reset.wb_stall got %b exp 0", wb_stall); end
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL reset.id_stall got %b exp 0", id_stall); end
    rst = 1'b0;
    model_reset();
    $display("test_reset: power-on state checked");
  endtask

  task automatic test_wb_only();
    idle();
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    #1;
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL wb_only.stall got %b exp 0", wb_stall); end
    tick();
    vectors++; if (reg_write !== 1'b1) begin miscompares++; $display("FAIL wb_only.rw got %b exp 1", reg_write); end
    vectors++; if (wt_addr !== 5'd5) begin miscompares++; $display("FAIL wb_only.addr got %0d exp 5", wt_addr); end
    vectors++; if (wt_data !== 32'h1234) begin miscompares++; $display("FAIL wb_only.data got %h exp 1234", wt_data); end
    wb_addr = 5'd0; wb_data = 32'h55;
    tick();
    vectors++; if (reg_write !== 1'b0) begin miscompares++; $display("FAIL wb_only.x0 got %b exp 0", reg_write); end
    idle();
    tick();
    $display("test_wb_only: x5 write and x0 suppression");
  endtask

  task automatic test_scoreboard();
    idle();
    issue(5'd7);
    id_rs1_addr = 5'd7;
    #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL sb.raw got %b exp 1", id_stall); end
    lu_valid = 1; lu_addr = 5'd7; lu_data = 32'hCAFE;
    #1;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL sb.ready got %b exp 1", lu_ready); end
    tick();
    lu_valid = 0;
    tick();
    vectors++; if (reg_write !== 1'b1 || wt_addr !== 5'd7 || wt_data !== 32'hCAFE) begin
      miscompares++; $display("FAIL sb.write got rw=%b x%0d=%h exp rw=1 x7=cafe", reg_write, wt_addr, wt_data); end
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL sb.hold got %b exp 1", id_stall); end
    tick();
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL sb.clear got %b exp 0", id_stall); end
    vectors++; if (reg_write !== 1'b0) begin miscompares++; $display("FAIL sb.idle got %b exp 0", reg_write); end
    idle();
    $display("test_scoreboard: x7 busy then released");
  endtask

  task automatic test_starvation();
    idle();
    issue(5'd3);
    wb_valid = 1; wb_addr = 5'd10; wb_data = 32'hA0;
    lu_valid = 1; lu_addr = 5'd3; lu_data = 32'h333;
    tick();
    lu_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      wb_data = 32'hA0 + k;
      #1;
      vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL starve.wb%0d stall got %b exp 0", k, wb_stall); end
      tick();
      vectors++; if (wt_addr !== 5'd10 || wt_data !== 32'hA0 + k) begin
        miscompares++; $display("FAIL starve.wb%0d got x%0d=%h exp x10=%h", k, wt_addr, wt_data, 32'hA0 + k); end
    end
    wb_data = 32'hB0;
    #1;
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL starve.force stall got %b exp 1", wb_stall); end
    tick();
    vectors++; if (reg_write !== 1'b1 || wt_addr !== 5'd3 || wt_data !== 32'h333) begin
      miscompares++; $display("FAIL starve.lu got rw=%b x%0d=%h exp x3=333", reg_write, wt_addr, wt_data); end
    #1;
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL starve.retry stall got %b exp 0", wb_stall); end
    tick();
    vectors++; if (wt_addr !== 5'd10 || wt_data !== 32'hB0) begin
      miscompares++; $display("FAIL starve.retry got x%0d=%h exp x10=b0", wt_addr, wt_data); end
    idle();
    tick();
    $display("test_starvation: forced LU write after %0d WB wins", MAX_WAIT);
  endtask

  task automatic test_full_fifo();
    logic [4:0] exp_a [3];
    exp_a[0] = 5'd11; exp_a[1] = 5'd12; exp_a[2] = 5'd13;
    idle();
    issue(5'd11); issue(5'd12); issue(5'd13);
    wb_valid = 1; wb_addr = 5'd20; wb_data = 32'hD0;
    for (int k = 0; k < 2; k++) begin
      lu_valid = 1; lu_addr = exp_a[k]; lu_data = 32'h1000 + k;
      #1;
      vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL full.push%0d ready got %b exp 1", k, lu_ready); end
      tick();
    end
    lu_addr = 5'd13; lu_data = 32'h1002;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL full.block%0d ready got %b exp 0", k, lu_ready); end
      tick();
    end
    #1;
    vectors++; if (lu_ready !== 1'b1 || wb_stall !== 1'b1) begin
      miscompares++; $display("FAIL full.pushpop got ready=%b stall=%b exp 1 1", lu_ready, wb_stall); end
    tick();
    lu_valid = 0;
    vectors++; if (wt_addr !== 5'd11 || wt_data !== 32'h1000) begin
      miscompares++; $display("FAIL full.pop0 got x%0d=%h exp x11=1000", wt_addr, wt_data); end
    tick();
    vectors++; if (wt_addr !== 5'd20) begin miscompares++; $display("FAIL full.wb got x%0d exp x20", wt_addr); end
    wb_valid = 0;
    for (int k = 1; k < 3; k++) begin
      tick();
      vectors++; if (reg_write !== 1'b1 || wt_addr !== exp_a[k] || wt_data !== 32'h1000 + k) begin
        miscompares++; $display("FAIL full.pop%0d got x%0d=%h exp x%0d=%h", k, wt_addr, wt_data, exp_a[k], 32'h1000 + k); end
    end
    tick();
    id_rs1_addr = 5'd11; id_rs2_addr = 5'd12; id_rd_addr = 5'd13; id_rd_valid = 1;
    #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL full.released got %b exp 0", id_stall); end
    idle();
    $display("test_full_fifo: full back-pressure and push/pop when full");
  endtask

  task automatic test_set_clear_race();
    idle();
    issue(5'd9);
    lu_valid = 1; lu_addr = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 0;
    tick();
    vectors++; if (reg_write !== 1'b1 || wt_addr !== 5'd9) begin
      miscompares++; $display("FAIL race.write got rw=%b x%0d exp x9", reg_write, wt_addr); end
    issue(5'd9);
    id_rs2_addr = 5'd9;
    #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL race.setwins got %b exp 1", id_stall); end
    lu_valid = 1; lu_data = 32'h98;
    tick();
    lu_valid = 0;
    tick();
    tick();
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL race.cleanup got %b exp 0", id_stall); end
    idle();
    $display("test_set_clear_race: issue beats same-edge clear on x9");
  endtask

  task automatic test_reset_midstream();
    idle();
    issue(5'd14); issue(5'd15);
    wb_valid = 1; wb_addr = 5'd21; wb_data = 32'hEE;
    lu_valid = 1; lu_addr = 5'd14; lu_data = 32'h14;
    tick();
    lu_addr = 5'd15; lu_data = 32'h15;
    tick();
    lu_valid = 0;
    id_rs1_addr = 5'd14; id_rs2_addr = 5'd15;
    #1;
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid.full got %b exp 0", lu_ready); end
    rst = 1'b1;
    #2;
    vectors++; if (reg_write !== 1'b0 || wt_addr !== 5'd0 || wt_data !== '0) begin
      miscompares++; $display("FAIL rstmid.outreg got rw=%b x%0d=%h exp 0", reg_write, wt_addr, wt_data); end
    vectors++; if (lu_ready !== 1'b1 || id_stall !== 1'b0 || wb_stall !== 1'b0) begin
      miscompares++; $display("FAIL rstmid.comb got ready=%b id=%b wb=%b exp 1 0 0", lu_ready, id_stall, wb_stall); end
    wb_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (reg_write !== 1'b0 || lu_ready !== 1'b1 || id_stall !== 1'b0) begin
        miscompares++; $display("FAIL rstmid.after%0d got rw=%b ready=%b id=%b exp 0 1 0", k, reg_write, lu_ready, id_stall); end
    end
    idle();
    $display("test_reset_midstream: queued LU results discarded");
  endtask

  task automatic test_random(input int cycles);
    int pend[$];
    bit hold;
    bit accept;
    int a, idx;
    hold = 0;
    idx = 0;
    for (int c = 0; c < cycles + 300; c++) begin
      if (c >= cycles && pend.size() == 0 && m_q.size() == 0 && !m_rw && !hold) break;
      if (!hold) begin
        wb_valid = 0;
        if (c < cycles && $urandom_range(0, 2) != 0) begin
          for (int t = 0; t < 8 && !wb_valid; t++) begin
            a = $urandom_range(0, 31);
            if (!m_busy[a]) begin wb_valid = 1; wb_addr = 5'(a); end
          end
          wb_data = $urandom;
        end
      end
      // ID never lets WB write a register an LU op still owns
      assert (!(wb_valid && m_busy[wb_addr]));
      lu_issue = 0;
      lu_issue_addr = 5'($urandom);
      if (c < cycles && $urandom_range(0, 3) == 0) begin
        a = $urandom_range(1, 31);
        if (!m_busy[a] && !(wb_valid && wb_addr == 5'(a))) begin lu_issue = 1; lu_issue_addr = 5'(a); end
      end
      lu_valid = 0;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, pend.size() - 1);
        lu_valid = 1; lu_addr = 5'(pend[idx]); lu_data = $urandom;
      end
      id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom);
      id_rd_addr = 5'($urandom); id_rd_valid = 1'($urandom);
      #1;
      model_comb();
      vectors++; if (wb_stall !== e_stall) begin miscompares++; $display("FAIL rnd%0d.wb_stall got %b exp %b", c, wb_stall, e_stall); end
      vectors++; if (lu_ready !== e_ready) begin miscompares++; $display("FAIL rnd%0d.lu_ready got %b exp %b", c, lu_ready, e_ready); end
      vectors++; if (id_stall !== e_id) begin miscompares++; $display("FAIL rnd%0d.id_stall got %b exp %b", c, id_stall, e_id); end
      hold = e_stall;
      accept = lu_valid && e_ready;
      tick();
      vectors++; if (reg_write !== m_rw) begin miscompares++; $display("FAIL rnd%0d.reg_write got %b exp %b", c, reg_write, m_rw); end
      if (m_rw) begin
        vectors++; if (wt_addr !== m_wa || wt_data !== m_wd) begin
          miscompares++; $display("FAIL rnd%0d.write got x%0d=%h exp x%0d=%h", c, wt_addr, wt_data, m_wa, m_wd); end
        $display("rnd %0d: write x%0d = %h (%s)", c, wt_addr, wt_data, m_wlu ? "lu" : "wb");
      end
      if (accept) pend.delete(idx);
      if (lu_issue) pend.push_back(int'(lu_issue_addr));
    end
    idle();
    tick();
    vectors++; if (pend.size() != 0 || m_q.size() != 0) begin
      miscompares++; $display("FAIL rnd.drain timeout pending=%0d queued=%0d exp 0", pend.size(), m_q.size()); end
    for (int r = 1; r < 32; r++) begin
      id_rs1_addr = 5'(r);
      #1;
      vectors++; if (id_stall !== m_busy[r]) begin miscompares++; $display("FAIL rnd.final_busy x%0d got %b exp %b", r, id_stall, m_busy[r]); end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_wb_only();
    test_scoreboard();
    test_starvation();
    test_full_fifo();
    test_set_clear_race();
    test_reset_midstream();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
